// File: rtl/align_shift_pipe.sv
// Pipelined right-shift aligner for the shared FP32 / dual-lane adder datapath.
// Lanes are repacked from the raw fraction, shifted independently, and returned with sticky bits.
package align_shift_pipe_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP16 = 2'd1, BF16 = 2'd2} fp_fmt_e;
endpackage

module align_shift_pipe
  import align_shift_pipe_pkg::*;
#(
  parameter int unsigned FRAC_W     = 24,
  parameter int unsigned LANE_W     = 8,
  parameter int unsigned STAGE_REGS = 0,
  parameter int unsigned TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  fp_fmt_e           fmt,
  input  logic [FRAC_W-1:0] X,
  input  logic [7:0]        S,
  input  logic [TAG_W-1:0]  tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W+1:0] R,
  output logic              Sticky_h,
  output logic              Sticky_l,
  output logic [TAG_W-1:0]  tag_o
);
  localparam int unsigned W  = FRAC_W + 2;
  localparam int unsigned LW = LANE_W + 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     d;
    logic             st_h;
    logic             st_l;
  } beat_t;

  // In dual mode the word holds hi lane at the top, lo lane at the bottom, zero gap between.
  // Shift amounts past the lane width drain every bit into sticky, which gives saturation.
  function automatic beat_t shift_step(input beat_t b, input logic dual, input int unsigned k,
                                       input logic sel_w, input logic sel_h, input logic sel_l);
    beat_t          o;
    logic [LW-1:0]  h;
    logic [LW-1:0]  l;
    o = b;
    h = b.d[W-1 -: LW];
    l = b.d[LW-1:0];
    if (!dual) begin
      if (sel_w) begin
        for (int unsigned i = 0; i < W; i++) if (i < k) o.st_l = o.st_l | b.d[i];
        o.d = b.d >> k;
      end
    end else begin
      if (sel_h) begin
        for (int unsigned i = 0; i < LW; i++) if (i < k) o.st_h = o.st_h | h[i];
        h = h >> k;
      end
      if (sel_l) begin
        for (int unsigned i = 0; i < LW; i++) if (i < k) o.st_l = o.st_l | l[i];
        l = l >> k;
      end
      o.d = '0;
      o.d[W-1 -: LW] = h;
      o.d[LW-1:0]    = l;
    end
    return o;
  endfunction

  logic       en;
  beat_t      in_beat, s16_beat, a_comb, a_beat, b_comb, b_beat, c_tmp, c_comb;
  logic       dual_c, a_dual, b_dual;
  logic [5:0] s_c, a_s;
  logic [3:0] b_s;
  logic       a_valid, b_valid;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign dual_c   = (fmt != FP32);
  // Remaining shift bits after the 16/8 stages: {hi[2:0], lo/fp32[2:0]}
  assign s_c      = {S[6:4], S[2:0]};

  always_comb begin
    in_beat     = '0;
    in_beat.tag = tag;
    if (!dual_c) begin
      in_beat.d = {X, 2'b00};
    end else begin
      in_beat.d[W-1 -: LW] = {X[FRAC_W-1 -: LANE_W], 2'b00};
      in_beat.d[LW-1:0]    = {X[LANE_W-1:0], 2'b00};
    end
    s16_beat = shift_step(in_beat, dual_c, 16, S[4], 1'b0, 1'b0);
    a_comb   = shift_step(s16_beat, dual_c, 8, S[3], S[7], S[3]);
  end

  if (STAGE_REGS >= 1) begin : g_cut_a
    beat_t      a_q;
    logic       a_dual_q, a_valid_q;
    logic [5:0] a_s_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_valid_q <= 1'b0;
        a_q       <= '0;
        a_dual_q  <= 1'b0;
        a_s_q     <= '0;
      end else if (en) begin
        a_valid_q <= in_valid;
        a_q       <= a_comb;
        a_dual_q  <= dual_c;
        a_s_q     <= s_c;
      end
    end
    assign a_valid = a_valid_q;
    assign a_beat  = a_q;
    assign a_dual  = a_dual_q;
    assign a_s     = a_s_q;
  end else begin : g_no_cut_a
    assign a_valid = in_valid;
    assign a_beat  = a_comb;
    assign a_dual  = dual_c;
    assign a_s     = s_c;
  end

  always_comb begin
    b_comb = shift_step(a_beat, a_dual, 4, a_s[2], a_s[5], a_s[2]);
  end

  if (STAGE_REGS >= 2) begin : g_cut_b
    beat_t      b_q;
    logic       b_dual_q, b_valid_q;
    logic [3:0] b_s_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        b_valid_q <= 1'b0;
        b_q       <= '0;
        b_dual_q  <= 1'b0;
        b_s_q     <= '0;
      end else if (en) begin
        b_valid_q <= a_valid;
        b_q       <= b_comb;
        b_dual_q  <= a_dual;
        b_s_q     <= {a_s[4:3], a_s[1:0]};
      end
    end
    assign b_valid = b_valid_q;
    assign b_beat  = b_q;
    assign b_dual  = b_dual_q;
    assign b_s     = b_s_q;
  end else begin : g_no_cut_b
    assign b_valid = a_valid;
    assign b_beat  = b_comb;
    assign b_dual  = a_dual;
    assign b_s     = {a_s[4:3], a_s[1:0]};
  end

  always_comb begin
    c_tmp  = shift_step(b_beat, b_dual, 2, b_s[1], b_s[3], b_s[1]);
    c_comb = shift_step(c_tmp, b_dual, 1, b_s[0], b_s[2], b_s[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      R         <= '0;
      Sticky_h  <= 1'b0;
      Sticky_l  <= 1'b0;
      tag_o     <= '0;
    end else if (en) begin
      out_valid <= b_valid;
      R         <= c_comb.d;
      Sticky_h  <= c_comb.st_h;
      Sticky_l  <= c_comb.st_l;
      tag_o     <= c_comb.tag;
    end
  end

endmodule

// File: tb/tb_align_shift_pipe.sv
// Scoreboarded bench for align_shift_pipe: an unpipelined instance and a two-cut instance
// are checked against an arithmetic reference model.
module tb_align_shift_pipe;
  import align_shift_pipe_pkg::*;

  localparam int FRAC_W = 24;
  localparam int LANE_W = 8;
  localparam int TAG_W  = 4;
  localparam int W      = FRAC_W + 2;
  localparam int LW     = LANE_W + 2;

  typedef struct packed {
    logic [W-1:0]     r;
    logic             sh;
    logic             sl;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid0 = 1'b0, in_valid2 = 1'b0, out_ready = 1'b0;
  fp_fmt_e           fmt = FP32;
  logic [FRAC_W-1:0] X = '0;
  logic [7:0]        S = '0;
  logic [TAG_W-1:0]  tag = '0;

  logic              in_ready0, out_valid0, sh0, sl0;
  logic [W-1:0]      r0;
  logic [TAG_W-1:0]  tag0;
  logic              in_ready2, out_valid2, sh2, sl2;
  logic [W-1:0]      r2;
  logic [TAG_W-1:0]  tag2;

  exp_t              q0[$];
  exp_t              q2[$];
  exp_t              e0, e2, held2;
  bit                hold2 = 0;
  int                n_tests = 0, n_fail = 0;
  int                n_acc2 = 0, n_ret2 = 0;
  logic [TAG_W-1:0]  tg = '0;

  align_shift_pipe #(.FRAC_W(FRAC_W), .LANE_W(LANE_W), .STAGE_REGS(0), .TAG_W(TAG_W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .fmt(fmt), .X(X),
    .S(S), .tag(tag), .out_valid(out_valid0), .out_ready(out_ready), .R(r0),
    .Sticky_h(sh0), .Sticky_l(sl0), .tag_o(tag0)
  );

  align_shift_pipe #(.FRAC_W(FRAC_W), .LANE_W(LANE_W), .STAGE_REGS(2), .TAG_W(TAG_W)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .fmt(fmt), .X(X),
    .S(S), .tag(tag), .out_valid(out_valid2), .out_ready(out_ready), .R(r2),
    .Sticky_h(sh2), .Sticky_l(sl2), .tag_o(tag2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, need finish before time limit");
    $fatal(1);
  end

  // One lane of the reference: widened value shifted right, saturating at the lane width.
  function automatic void lane(input longint unsigned v, input int sa, input int width,
                               output longint unsigned r, output bit st);
    if (sa >= width) begin
      r  = 0;
      st = (v != 0);
    end else begin
      r  = v >> sa;
      st = (v & ((64'd1 << sa) - 64'd1)) != 0;
    end
  endfunction

  function automatic exp_t model(input fp_fmt_e f, input logic [FRAC_W-1:0] x,
                                 input logic [7:0] s, input logic [TAG_W-1:0] t);
    exp_t              e;
    longint unsigned   rh, rl;
    bit                sth, stl;
    logic [63:0]       w;
    logic [LANE_W-1:0] xh, xl;
    e.tag = t;
    if (f == FP32) begin
      lane(longint'(x) * 4, int'(s[4:0]), W, rl, stl);
      sth = 0;
      w   = rl;
    end else begin
      xh = x[FRAC_W-1 -: LANE_W];
      xl = x[LANE_W-1:0];
      lane(longint'(xh) * 4, int'(s[7:4]), LW, rh, sth);
      lane(longint'(xl) * 4, int'(s[3:0]), LW, rl, stl);
      w = (rh << (W - LW)) | rl;
    end
    e.r  = w[W-1:0];
    e.sh = sth;
    e.sl = stl;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got R=%h sh=%b sl=%b tag=%h, need R=%h sh=%b sl=%b tag=%h", nm,
               act.r, act.sh, act.sl, act.tag, exp.r, exp.sh, exp.sl, exp.tag);
    end
  endtask

  // Scoreboard and monitor: sampled mid-cycle, where handshakes for the next edge are stable.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q2.delete();
      hold2  = 0;
      n_acc2 = 0;
      n_ret2 = 0;
    end else begin
      if (hold2) begin
        n_tests++;
        if (!out_valid2 || {r2, sh2, sl2, tag2} !== held2) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b %h, need v=1 %h", out_valid2,
                   {r2, sh2, sl2, tag2}, held2);
        end
      end
      hold2 = out_valid2 && !out_ready;
      held2 = {r2, sh2, sl2, tag2};
      if (in_valid0 && in_ready0) q0.push_back(model(fmt, X, S, tag));
      if (in_valid2 && in_ready2) begin
        q2.push_back(model(fmt, X, S, tag));
        n_acc2++;
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut0_extra: got tag %h, need no output", tag0);
        end else begin
          e0 = q0.pop_front();
          cmp("dut0_beat", {r0, sh0, sl0, tag0}, e0);
        end
      end
      if (out_valid2 && out_ready) begin
        n_ret2++;
        if (q2.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut2_extra: got tag %h, need no output", tag2);
        end else begin
          e2 = q2.pop_front();
          cmp("dut2_beat", {r2, sh2, sl2, tag2}, e2);
        end
      end
    end
  end

  task automatic issue(input bit to0, input bit to2, input fp_fmt_e f,
                       input logic [FRAC_W-1:0] x, input logic [7:0] s);
    bit ok = 0;
    fmt       = f;
    X         = x;
    S         = s;
    tag       = tg;
    in_valid0 = to0;
    in_valid2 = to2;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((to0 && in_ready0) || (to2 && in_ready2)) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    tg        = tg + 1'b1;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0, need accept within 100 cycles");
    end
  endtask

  // Single beat into an idle pipe with out_ready high: check payload and latency on both.
  task automatic dir(input string nm, input fp_fmt_e f, input logic [FRAC_W-1:0] x,
                     input logic [7:0] s, input logic [W-1:0] er, input logic esh,
                     input logic esl);
    int l0 = 0;
    int l2 = 0;
    issue(1, 1, f, x, s);
    for (int c = 1; c <= 6; c++) begin
      if (out_valid0 && l0 == 0) begin
        l0 = c;
        check({nm, "_r0"}, 64'(r0), 64'(er));
        check({nm, "_st0"}, {62'd0, sh0, sl0}, {62'd0, esh, esl});
      end
      if (out_valid2 && l2 == 0) begin
        l2 = c;
        check({nm, "_r2"}, 64'(r2), 64'(er));
        check({nm, "_st2"}, {62'd0, sh2, sl2}, {62'd0, esh, esl});
      end
      @(posedge clk);
      #1;
    end
    check({nm, "_lat0"}, 64'(l0), 64'd1);
    check({nm, "_lat2"}, 64'(l2), 64'd3);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (q0.size() == 0 && q2.size() == 0 && !out_valid0 && !out_valid2) break;
      @(posedge clk);
      #1;
    end
    check("drain_q2", 64'(q2.size()), 64'd0);
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_count", 64'(n_ret2), 64'(n_acc2));
  endtask

  logic [FRAC_W-1:0] rx;
  logic [7:0]        rs;
  bit                done;
  int                acc_before, ret_before;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", {62'd0, out_valid0, out_valid2}, 64'd0);
    check("rst_r", {r0, r2}, 64'd0);
    check("rst_ready", {62'd0, in_ready0, in_ready2}, 64'd3);

    out_ready = 1'b1;
    dir("fp32_s1", FP32, 24'h800001, 8'h01, 26'h1000002, 1'b0, 1'b0);
    dir("fp32_s3", FP32, 24'h800001, 8'h03, 26'h0400000, 1'b0, 1'b1);
    dir("fp32_s_hi", FP32, 24'h800001, 8'hE1, 26'h1000002, 1'b0, 1'b0);
    dir("dual_a", FP16, 24'hFF5A81, 8'h23, 26'h0FF0040, 1'b0, 1'b1);
    dir("dual_gap", BF16, 24'hFF0081, 8'h23, 26'h0FF0040, 1'b0, 1'b1);
    dir("sat26", FP32, 24'h000001, 8'd26, 26'h0, 1'b0, 1'b1);
    dir("sat31", FP32, 24'h000001, 8'd31, 26'h0, 1'b0, 1'b1);
    dir("fp32_s25", FP32, 24'h800001, 8'd25, 26'h0000001, 1'b0, 1'b1);
    dir("dual_sat", FP16, 24'h3C00AB, 8'hF0, 26'h00002AC, 1'b1, 1'b0);
    dir("dual_s9", BF16, 24'hFF00FF, 8'h99, 26'h0010001, 1'b1, 1'b1);

    // Streaming with random backpressure, alternating formats.
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rx = FRAC_W'($urandom);
          rs = 8'($urandom);
          if (i % 2 == 0) issue(0, 1, FP32, rx, rs);
          else issue(0, 1, ($urandom_range(0, 1) != 0) ? FP16 : BF16, rx, rs);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Fill the pipe against a stalled output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx = FRAC_W'($urandom);
      rs = 8'($urandom);
      issue(0, 1, (i == 1) ? FP16 : FP32, rx, rs);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready2), 64'd0);
    end
    @(posedge clk);
    #1;
    acc_before = n_acc2;
    ret_before = n_ret2;
    out_ready  = 1'b1;
    issue(0, 1, BF16, 24'h12AB34, 8'h57);
    check("swap_accept", 64'(n_acc2 - acc_before), 64'd1);
    check("swap_retire", 64'(n_ret2 - ret_before), 64'd1);
    out_ready = 1'b0;

    // Reset with three beats in flight.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_valid", 64'(out_valid2), 64'd0);
    check("rst2_r", 64'(r2), 64'd0);
    check("rst2_tag", 64'(tag2), 64'd0);
    check("rst2_ready", 64'(in_ready2), 64'd1);
    out_ready = 1'b1;
    dir("post_rst", FP32, 24'h800001, 8'h00, 26'h2000004, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
